// File: rtl/rx_ad56x3_pkg.sv
// Shared AD56x3 frame definitions, used by both the driver side and the receiver.
package rx_ad56x3_pkg;

    localparam int FRAME_LEN = 24;
    localparam int CMD_MSB   = 21;
    localparam int CMD_LSB   = 19;
    localparam int ADDR_MSB  = 18;
    localparam int ADDR_LSB  = 16;
    localparam int DATA_MSB  = 15;

    localparam logic [2:0] ADDR_CH_A = 3'b000;
    localparam logic [2:0] ADDR_CH_B = 3'b001;

    typedef logic [1:0] rxState_t;
    localparam rxState_t ST_IDLE  = 2'd0;
    localparam rxState_t ST_SHIFT = 2'd1;
    localparam rxState_t ST_DONE  = 2'd2;

endpackage

// File: rtl/rx_ad56x3_if.sv
// Avalon-ST source bundle carrying one decoded AD56x3 frame per transfer.
interface rx_ad56x3_if #(
    parameter int DATA_WIDTH = 14
);
    logic                  asoValid;
    logic                  asoChannel;
    logic [DATA_WIDTH-1:0] asoData;
    logic [2:0]            asoCmd;
    logic                  asoRdy;

    modport master (
        output asoValid,
        output asoChannel,
        output asoData,
        output asoCmd,
        input  asoRdy
    );

    modport slave (
        input  asoValid,
        input  asoChannel,
        input  asoData,
        input  asoCmd,
        output asoRdy
    );
endinterface

// File: rtl/rx_ad56x3_sync2ff.sv
// Two-flop synchronizer with a configurable idle level applied during reset.
module sync2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/rx_ad56x3.sv
// AD56x3 serial-frame receiver: oversamples SYNC/SCLK/DIN, decodes 24-bit frames
// and presents them on an Avalon-ST source with overflow and frame-error pulses.
module rx_ad56x3
    import rx_ad56x3_pkg::*;
#(
    parameter int    DATA_WIDTH = 14,
    parameter string SIGN_A     = "UNSIGNED",
    parameter string SIGN_B     = "UNSIGNED"
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dacSync,
    input  logic        dacSclk,
    input  logic        dacDin,
    rx_ad56x3_if.master aso,
    output logic        frameErr,
    output logic        overflow
);
    localparam bit SIGNED_A = (SIGN_A == "SIGNED");
    localparam bit SIGNED_B = (SIGN_B == "SIGNED");

    logic syncS, sclkS, dinS;

    sync2ff #(.RESET_VAL(1'b1)) uSyncSync (.clk(clk), .reset(reset), .d_i(dacSync), .q_o(syncS));
    sync2ff #(.RESET_VAL(1'b1)) uSyncSclk (.clk(clk), .reset(reset), .d_i(dacSclk), .q_o(sclkS));
    sync2ff #(.RESET_VAL(1'b0)) uSyncDin  (.clk(clk), .reset(reset), .d_i(dacDin),  .q_o(dinS));

    logic                 syncPrev_q, sclkPrev_q;
    logic [1:0]           warm_q;
    logic                 armed_q;
    rxState_t             state_q, state_d;
    logic [FRAME_LEN-1:0] shift_q, shift_d;
    logic [4:0]           bitCnt_q, bitCnt_d;

    logic                  valid_q, valid_d;
    logic                  chan_q, chan_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [2:0]            cmd_q, cmd_d;
    logic                  frameErr_q, frameErr_d;
    logic                  overflow_q, overflow_d;

    logic                  syncFall, syncRise, sclkFall;
    logic                  frameDone, frameAbort;
    logic [FRAME_LEN-1:0]  frameNext;
    logic [2:0]            addr;
    logic                  addrOk, newChan, chanSigned;
    logic [DATA_WIDTH-1:0] rawData, newData;
    logic                  unusedBits;

    assign syncFall = syncPrev_q & ~syncS;
    assign syncRise = ~syncPrev_q & syncS;
    assign sclkFall = sclkPrev_q & ~sclkS;

    assign frameNext  = {shift_q[FRAME_LEN-2:0], dinS};
    assign addr       = frameNext[ADDR_MSB:ADDR_LSB];
    assign addrOk     = (addr == ADDR_CH_A) || (addr == ADDR_CH_B);
    assign newChan    = (addr == ADDR_CH_B);
    assign chanSigned = newChan ? SIGNED_B : SIGNED_A;
    assign rawData    = frameNext[DATA_MSB -: DATA_WIDTH];
    assign newData    = rawData ^ {chanSigned, {(DATA_WIDTH-1){1'b0}}};
    assign unusedBits = ^{shift_q[FRAME_LEN-1], frameNext};

    // A frame may only start once SYNC has been seen high on a real post-reset
    // sample, so a frame cut short by reset is not mistaken for a new one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            syncPrev_q <= 1'b1;
            sclkPrev_q <= 1'b1;
            warm_q     <= 2'b00;
            armed_q    <= 1'b0;
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bitCnt_q   <= '0;
        end else begin
            syncPrev_q <= syncS;
            sclkPrev_q <= sclkS;
            warm_q     <= {warm_q[0], 1'b1};
            armed_q    <= armed_q | (warm_q[1] & syncS);
            state_q    <= state_d;
            shift_q    <= shift_d;
            bitCnt_q   <= bitCnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bitCnt_d   = bitCnt_q;
        frameDone  = 1'b0;
        frameAbort = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (syncFall && armed_q) begin
                    state_d  = ST_SHIFT;
                    shift_d  = '0;
                    bitCnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (syncRise) begin
                    state_d    = ST_IDLE;
                    frameAbort = 1'b1;
                end else if (sclkFall) begin
                    shift_d  = frameNext;
                    bitCnt_d = bitCnt_q + 5'd1;
                    if (bitCnt_q == 5'(FRAME_LEN - 1)) begin
                        state_d   = ST_DONE;
                        frameDone = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (syncRise) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A frame completing in the same cycle as a handshake replaces the held one.
    always_comb begin
        valid_d    = valid_q;
        chan_d     = chan_q;
        data_d     = data_q;
        cmd_d      = cmd_q;
        frameErr_d = frameAbort;
        overflow_d = 1'b0;
        if (valid_q && aso.asoRdy) begin
            valid_d = 1'b0;
        end
        if (frameDone) begin
            if (!addrOk) begin
                frameErr_d = 1'b1;
            end else if (!valid_q || aso.asoRdy) begin
                valid_d = 1'b1;
                chan_d  = newChan;
                data_d  = newData;
                cmd_d   = frameNext[CMD_MSB:CMD_LSB];
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            chan_q     <= 1'b0;
            data_q     <= '0;
            cmd_q      <= '0;
            frameErr_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            chan_q     <= chan_d;
            data_q     <= data_d;
            cmd_q      <= cmd_d;
            frameErr_q <= frameErr_d;
            overflow_q <= overflow_d;
        end
    end

    assign aso.asoValid   = valid_q;
    assign aso.asoChannel = chan_q;
    assign aso.asoData    = data_q;
    assign aso.asoCmd     = cmd_q;
    assign frameErr       = frameErr_q;
    assign overflow       = overflow_q;
endmodule

// File: tb/tb_rx_ad56x3.sv
// Directed-vector bench for rx_ad56x3: channel A unsigned, channel B signed.
module tb_rx_ad56x3;
    localparam int DW = 14;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic dacSync = 1'b1;
    logic dacSclk = 1'b1;
    logic dacDin  = 1'b0;
    logic frameErr, overflow;

    rx_ad56x3_if #(.DATA_WIDTH(DW)) asoBus();

    rx_ad56x3 #(
        .DATA_WIDTH(DW),
        .SIGN_A("UNSIGNED"),
        .SIGN_B("SIGNED")
    ) dut (
        .clk(clk),
        .reset(reset),
        .dacSync(dacSync),
        .dacSclk(dacSclk),
        .dacDin(dacDin),
        .aso(asoBus),
        .frameErr(frameErr),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    cmd;
        logic [2:0]    addr;
        logic [DW-1:0] code;
        bit            isSigned;
        int            expRises;
        logic          expChan;
        logic [DW-1:0] expData;
        int            expErrs;
    } vec_t;

    vec_t vecs[7];

    int checks = 0;
    int errors = 0;
    int validRises = 0;
    int errPulses = 0;
    int ovfPulses = 0;
    int accepts = 0;
    logic          prevValid = 1'b0;
    logic          capChan = 1'b0;
    logic [DW-1:0] capData = '0;
    logic [2:0]    capCmd = '0;

    // Event monitor sampled on the falling clock edge, away from output updates.
    always @(negedge clk) begin
        if (frameErr) errPulses++;
        if (overflow) ovfPulses++;
        if (asoBus.asoValid && asoBus.asoRdy) accepts++;
        if (asoBus.asoValid && !prevValid) begin
            validRises++;
            capChan = asoBus.asoChannel;
            capData = asoBus.asoData;
            capCmd  = asoBus.asoCmd;
        end
        prevValid = asoBus.asoValid;
    end

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearCounts();
        validRises = 0;
        errPulses  = 0;
        ovfPulses  = 0;
        accepts    = 0;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Driver side converts two's complement to offset binary for signed channels.
    function automatic logic [23:0] buildFrame(input logic [2:0] cmd, input logic [2:0] addr,
                                               input logic [DW-1:0] code, input bit isSigned);
        logic [DW-1:0] sent;
        sent = isSigned ? (code ^ 14'h2000) : code;
        return {2'b00, cmd, addr, sent, 2'b00};
    endfunction

    task automatic drvAd56x3(input logic [23:0] f, input int nBits, input bit raiseSync);
        dacSync = 1'b0;
        waitClk(4);
        for (int i = 0; i < nBits; i++) begin
            dacDin = f[23 - i];
            waitClk(4);
            dacSclk = 1'b0;
            waitClk(4);
            dacSclk = 1'b1;
        end
        waitClk(4);
        if (raiseSync) begin
            dacSync = 1'b1;
            dacDin  = 1'b0;
            waitClk(8);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        clearCounts();
        drvAd56x3(buildFrame(v.cmd, v.addr, v.code, v.isSigned), 24, 1'b1);
        waitClk(6);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{3'b011, 3'b000, 14'h1234, 1'b0, 1, 1'b0, 14'h1234, 0};
        vecs[1] = '{3'b011, 3'b001, 14'h3FFF, 1'b1, 1, 1'b1, 14'h3FFF, 0};
        vecs[2] = '{3'b001, 3'b000, 14'h3FFF, 1'b0, 1, 1'b0, 14'h3FFF, 0};
        vecs[3] = '{3'b010, 3'b001, 14'h0000, 1'b1, 1, 1'b1, 14'h0000, 0};
        vecs[4] = '{3'b011, 3'b111, 14'h0555, 1'b0, 0, 1'b0, 14'h0000, 1};
        vecs[5] = '{3'b000, 3'b000, 14'h0001, 1'b0, 1, 1'b0, 14'h0001, 0};
        vecs[6] = '{3'b111, 3'b001, 14'h2000, 1'b1, 1, 1'b1, 14'h2000, 0};

        asoBus.asoRdy = 1'b1;
        reset = 1'b1;
        waitClk(3);
        checkOutput("rst.valid", int'(asoBus.asoValid), 0);
        checkOutput("rst.chan", int'(asoBus.asoChannel), 0);
        checkOutput("rst.data", int'(asoBus.asoData), 0);
        checkOutput("rst.cmd", int'(asoBus.asoCmd), 0);
        checkOutput("rst.frameErr", int'(frameErr), 0);
        checkOutput("rst.overflow", int'(overflow), 0);
        reset = 1'b0;
        waitClk(6);
        checkOutput("postrst.valid", int'(asoBus.asoValid), 0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d.rises", i), validRises, vecs[i].expRises);
            checkOutput($sformatf("v%0d.frameErr", i), errPulses, vecs[i].expErrs);
            checkOutput($sformatf("v%0d.overflow", i), ovfPulses, 0);
            if (vecs[i].expRises == 1) begin
                checkOutput($sformatf("v%0d.chan", i), int'(capChan), int'(vecs[i].expChan));
                checkOutput($sformatf("v%0d.data", i), int'(capData), int'(vecs[i].expData));
                checkOutput($sformatf("v%0d.cmd", i), int'(capCmd), int'(vecs[i].cmd));
            end
        end

        $display("[TB] aborted frame after 10 bits");
        clearCounts();
        drvAd56x3(buildFrame(3'b011, 3'b000, 14'h0ABC, 1'b0), 10, 1'b1);
        waitClk(6);
        checkOutput("abort.frameErr", errPulses, 1);
        checkOutput("abort.rises", validRises, 0);
        clearCounts();
        drvAd56x3(buildFrame(3'b011, 3'b000, 14'h0001, 1'b0), 24, 1'b1);
        waitClk(6);
        checkOutput("abort.next.rises", validRises, 1);
        checkOutput("abort.next.data", int'(capData), 14'h0001);
        checkOutput("abort.next.frameErr", errPulses, 0);

        $display("[TB] backpressure over two frames");
        asoBus.asoRdy = 1'b0;
        clearCounts();
        drvAd56x3(buildFrame(3'b011, 3'b000, 14'h0AAA, 1'b0), 24, 1'b1);
        drvAd56x3(buildFrame(3'b011, 3'b000, 14'h1555, 1'b0), 24, 1'b1);
        waitClk(4);
        checkOutput("bp.rises", validRises, 1);
        checkOutput("bp.valid", int'(asoBus.asoValid), 1);
        checkOutput("bp.data", int'(asoBus.asoData), 14'h0AAA);
        checkOutput("bp.overflow", ovfPulses, 1);
        checkOutput("bp.accepts", accepts, 0);
        asoBus.asoRdy = 1'b1;
        waitClk(2);
        checkOutput("bp.drain.valid", int'(asoBus.asoValid), 0);
        checkOutput("bp.drain.accepts", accepts, 1);

        $display("[TB] reset in the middle of a frame");
        clearCounts();
        drvAd56x3(buildFrame(3'b011, 3'b000, 14'h0F0F, 1'b0), 12, 1'b0);
        reset = 1'b1;
        waitClk(3);
        reset = 1'b0;
        clearCounts();
        waitClk(4);
        dacSync = 1'b1;
        dacDin  = 1'b0;
        waitClk(8);
        for (int i = 0; i < 3; i++) begin
            dacSclk = 1'b0;
            waitClk(4);
            dacSclk = 1'b1;
            waitClk(4);
        end
        drvAd56x3(buildFrame(3'b011, 3'b000, 14'h2000, 1'b0), 24, 1'b1);
        waitClk(6);
        checkOutput("rstmid.rises", validRises, 1);
        checkOutput("rstmid.data", int'(capData), 14'h2000);
        checkOutput("rstmid.frameErr", errPulses, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rx_ad56x3.md
RX_AD56X3 -- requirements
Module: rx_ad56x3

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 14, giving payload width per frame (12, 14 or 16).
REQ-002 SHALL have parameter SIGN_A, default "UNSIGNED", giving channel A output format ("UNSIGNED" or "SIGNED").
REQ-003 SHALL have parameter SIGN_B, default "UNSIGNED", giving channel B output format ("UNSIGNED" or "SIGNED").
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port dacSync, input, 1, AD56x3 SYNC, active-low frame enable.
REQ-007 SHALL have port dacSclk, input, 1, AD56x3 serial clock; data is sampled on its falling edge.
REQ-008 SHALL have port dacDin, input, 1, AD56x3 serial data, MSB first.
REQ-009 SHALL have port asoValid, output, 1, Avalon-ST valid for the decoded frame.
REQ-010 SHALL have port asoChannel, output, 1, decoded channel (0 = A, 1 = B).
REQ-011 SHALL have port asoData, output, DATA_WIDTH, decoded DAC code.
REQ-012 SHALL have port asoCmd, output, 3, frame command bits C2..C0.
REQ-013 SHALL have port asoRdy, input, 1, Avalon-ST ready from the sink.
REQ-014 SHALL have port frameErr, output, 1, one-cycle pulse on an aborted or malformed frame.
REQ-015 SHALL have port overflow, output, 1, one-cycle pulse when a completed frame is dropped.

Function
REQ-016 SHALL pass dacSync, dacSclk and dacDin through 2-FF synchronizers; dacSclk falling edge is detected on the synchronized value.
REQ-017 SHALL operate correctly when each dacSclk level is held for at least 2 clk periods; faster input is out of scope.
REQ-018 SHALL implement FSM IDLE -> SHIFT on synchronized dacSync falling; SHIFT -> DONE on the 24th dacSclk falling edge; DONE -> IDLE on dacSync rising.
REQ-019 SHALL shift dacDin into a 24-bit register MSB first, one bit per dacSclk falling edge, only in SHIFT.
REQ-020 SHALL decode frame bits: [23:22] don't care, [21:19] command, [18:16] address, [15:16-DATA_WIDTH] data, remaining LSBs don't care.
REQ-021 SHALL map address 3'b000 to channel 0 and 3'b001 to channel 1; any other address pulses frameErr and emits no output.
REQ-022 SHALL invert the data MSB (offset binary -> two's complement) for a channel whose SIGN parameter is "SIGNED", else pass data unchanged.
REQ-023 SHALL load the output register and assert asoValid on the clk cycle following the detected 24th falling edge.
REQ-024 SHALL hold asoValid, asoChannel, asoData and asoCmd stable until a cycle with asoValid and asoRdy both high, then deassert asoValid on the next cycle unless a new frame completes in that same cycle, in which case the new frame is loaded and asoValid stays high.
REQ-025 SHALL, when a frame completes while asoValid is high and asoRdy is low, keep the held frame, drop the new one and pulse overflow.
REQ-026 SHALL, if dacSync rises in SHIFT before 24 falling edges, discard the frame, pulse frameErr and return to IDLE.
REQ-027 SHALL ignore dacSclk falling edges in DONE and in IDLE.
REQ-028 SHALL treat a dacSync falling edge seen while in DONE as a new frame start after the intervening rising edge; a frame is never restarted without dacSync high for at least one synchronized sample.

Reset
REQ-029 SHALL on reset drive asoValid, asoChannel, asoData, asoCmd, frameErr and overflow to 0, clear the shift register and bit counter, set synchronizers to idle levels (dacSync 1, dacSclk 1, dacDin 0) and enter IDLE.
REQ-030 SHALL discard a partially received frame on reset mid-frame without pulsing frameErr after reset deasserts; the next complete frame decodes normally.

Structure
REQ-031 SHALL take the frame length (24), field bit positions, address codes and FSM state enum from a shared package common to the AD56x3 driver and this block.
REQ-032 SHALL place the 2-FF synchronizer in one sub-module, sync2ff, instantiated once per serial input.

Verification
REQ-033 SHALL test: drvAd56x3 sends channel 0 data 14'h1234 at SIGN_A "UNSIGNED" -> one asoValid, asoChannel 0, asoData 14'h1234, asoCmd 3'b011.
REQ-034 SHALL test: SIGN_B "SIGNED" with driver input 14'h3FFF (-1) on channel 1 -> asoData 14'h3FFF, asoChannel 1.
REQ-035 SHALL test: dacSync raised after 10 dacSclk falls -> frameErr pulses 1 cycle, no asoValid; the next full frame with 14'h0001 decodes correctly.
REQ-036 SHALL test: asoRdy held 0 over two frames (14'h0AAA then 14'h1555) -> asoData stays 14'h0AAA, overflow pulses once.
REQ-037 SHALL test: address 3'b111 frame -> frameErr pulse, no asoValid.
REQ-038 SHALL test: reset asserted after 12 bits, then a full frame 14'h2000 -> exactly one asoValid with 14'h2000 and no frameErr.
